// File: rtl/orpsoc_sim_ctrl_pkg.sv
// orpsoc_sim_ctrl_pkg
//   Shared definitions for the orpsoc simulation control block:
//   register word indices (wb_adr_i[4:2]), the exit code reported on a
//   watchdog expiry, and the reset-sequencer state type.
package orpsoc_sim_ctrl_pkg;

  localparam logic [2:0] REG_EXIT    = 3'd0;
  localparam logic [2:0] REG_CONSOLE = 3'd1;
  localparam logic [2:0] REG_CYC_LO  = 3'd2;
  localparam logic [2:0] REG_CYC_HI  = 3'd3;
  localparam logic [2:0] REG_WDT     = 3'd4;
  localparam logic [2:0] REG_SWRST   = 3'd5;

  localparam logic [7:0] EXIT_TIMEOUT = 8'hFF;

  typedef enum logic [1:0] {
    SEQ_HOLD  = 2'd0,
    SEQ_STAGE = 2'd1,
    SEQ_RUN   = 2'd2
  } seq_state_e;

  // Words 6 and 7 are not backed by any register and answer with an error.
  function automatic logic is_mapped(input logic [2:0] word);
    return word <= REG_SWRST;
  endfunction

endpackage

// File: rtl/orpsoc_rst_seq.sv
// orpsoc_rst_seq
//   Staged reset sequencer. All reset outputs are held while srst is high;
//   once srst drops, rst_o[k] is released (k+1)*RST_STAGE_CYCLES cycles
//   after the first cycle with srst low. A software restart (swrst)
//   re-asserts rst_o[NUM_RST-1:1] and replays the sequence from stage 1;
//   rst_o[0] is the CPU/bus domain and is never re-asserted by software.
// Ports:
//   clk    in  : clock
//   srst   in  : synchronous active-high reset
//   swrst  in  : one-cycle software restart request
//   rst_o  out : NUM_RST active-high staged resets
module orpsoc_rst_seq
  import orpsoc_sim_ctrl_pkg::*;
#(
  parameter int NUM_RST          = 2,
  parameter int RST_STAGE_CYCLES = 10
) (
  input  logic               clk,
  input  logic               srst,
  input  logic               swrst,
  output logic [NUM_RST-1:0] rst_o
);

  localparam int CW = $clog2(RST_STAGE_CYCLES + 1);
  localparam int SW = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_RST - 1);
  localparam logic [CW-1:0] STAGE_LEN  = CW'(RST_STAGE_CYCLES);

  seq_state_e         state_reg, state_next;
  logic [SW-1:0]      stage_reg, stage_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [NUM_RST-1:0] rst_reg, rst_next;
  logic [CW-1:0]      cnt_inc;

  assign cnt_inc = cnt_reg + CW'(1);

  always_comb begin
    state_next = state_reg;
    stage_next = stage_reg;
    cnt_next   = cnt_reg;
    rst_next   = rst_reg;

    case (state_reg)
      // HOLD is only ever seen with srst low for a single edge; that edge is
      // already the first counted cycle of stage 0, so it shares STAGE logic.
      SEQ_HOLD, SEQ_STAGE: begin
        state_next = SEQ_STAGE;
        if (cnt_inc == STAGE_LEN) begin
          cnt_next = '0;
          for (int i = 0; i < NUM_RST; i++) begin
            if (stage_reg == SW'(i)) rst_next[i] = 1'b0;
          end
          if (stage_reg == LAST_STAGE) state_next = SEQ_RUN;
          else                         stage_next = stage_reg + SW'(1);
        end else begin
          cnt_next = cnt_inc;
        end
      end
      SEQ_RUN: ;
      default: state_next = SEQ_HOLD;
    endcase

    // Restart from stage 1. While stage 0 is still pending the request has
    // nothing to undo, so the sequence simply continues.
    if ((NUM_RST > 1) && swrst &&
        ((state_reg == SEQ_RUN) || ((state_reg == SEQ_STAGE) && (stage_reg != '0)))) begin
      state_next  = SEQ_STAGE;
      stage_next  = SW'(1);
      cnt_next    = '0;
      rst_next    = '1;
      rst_next[0] = rst_reg[0];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= SEQ_HOLD;
      stage_reg <= '0;
      cnt_reg   <= '0;
      rst_reg   <= '1;
    end else begin
      state_reg <= state_next;
      stage_reg <= stage_next;
      cnt_reg   <= cnt_next;
      rst_reg   <= rst_next;
    end
  end

  assign rst_o = rst_reg;

endmodule

// File: rtl/orpsoc_sim_ctrl.sv
// orpsoc_sim_ctrl
//   Wishbone classic slave controlling an orpsoc simulation: staged resets,
//   exit/pass-fail register, console byte port, coherent 64-bit cycle
//   counter and a reloadable watchdog.
// Ports:
//   wb_clk_i, wb_rst_i          : clock, synchronous active-high reset
//   wb_adr_i/dat_i/we_i/cyc_i/stb_i : Wishbone request (word = adr[4:2])
//   wb_dat_o/ack_o/err_o        : registered response, one wait state
//   rst_o                       : staged domain resets
//   done_o, exit_code_o         : sticky finish flag and its exit code
//   timeout_o                   : sticky watchdog expiry flag
//   char_valid_o, char_o        : one-cycle console byte strobe and data
// CYC_INIT is the cycle counter value loaded by reset (normally zero).
module orpsoc_sim_ctrl
  import orpsoc_sim_ctrl_pkg::*;
#(
  parameter int          NUM_RST          = 2,
  parameter int          RST_STAGE_CYCLES = 10,
  parameter logic [31:0] TIMEOUT_CYCLES   = 32'd0,
  parameter logic [63:0] CYC_INIT         = 64'd0
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic [NUM_RST-1:0] rst_o,
  output logic               done_o,
  output logic [7:0]         exit_code_o,
  output logic               timeout_o,
  output logic               char_valid_o,
  output logic [7:0]         char_o
);

  logic        ack_reg, err_reg;
  logic [31:0] dat_reg;
  logic        done_reg, timeout_reg;
  logic [7:0]  exit_code_reg;
  logic        char_valid_reg;
  logic [7:0]  char_reg;
  logic [63:0] cyc_cnt_reg;
  logic [31:0] cyc_hi_snap_reg;
  logic [31:0] wdt_reg;

  logic [2:0]  word;
  logic        bus_req, mapped, wr, rd;
  logic        wdt_wr, exit_wr, wdt_expire, swrst_req;
  logic        unused_bits;

  assign word = wb_adr_i[4:2];
  assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  // No new request is taken in the cycle carrying a response, which gives a
  // held strobe exactly one response every two cycles.
  assign bus_req = wb_cyc_i & wb_stb_i & ~ack_reg & ~err_reg;
  assign mapped  = is_mapped(word);
  assign wr      = bus_req & mapped & wb_we_i;
  assign rd      = bus_req & mapped & ~wb_we_i;

  assign wdt_wr     = wr & (word == REG_WDT);
  assign exit_wr    = wr & (word == REG_EXIT) & ~done_reg;
  // A WDT write in the same cycle wins over the decrement, so no expiry then.
  assign wdt_expire = (wdt_reg == 32'd1) & ~done_reg & ~wdt_wr;
  assign swrst_req  = wr & (word == REG_SWRST) & wb_dat_i[0];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg         <= 1'b0;
      err_reg         <= 1'b0;
      dat_reg         <= '0;
      done_reg        <= 1'b0;
      timeout_reg     <= 1'b0;
      exit_code_reg   <= '0;
      char_valid_reg  <= 1'b0;
      char_reg        <= '0;
      cyc_cnt_reg     <= CYC_INIT;
      cyc_hi_snap_reg <= '0;
      wdt_reg         <= TIMEOUT_CYCLES;
    end else begin
      ack_reg        <= bus_req & mapped;
      err_reg        <= bus_req & ~mapped;
      char_valid_reg <= 1'b0;
      dat_reg        <= '0;

      if (rd) begin
        case (word)
          REG_CYC_LO: begin
            // Capture the high half with the low half so a LO/HI pair is coherent.
            dat_reg         <= cyc_cnt_reg[31:0];
            cyc_hi_snap_reg <= cyc_cnt_reg[63:32];
          end
          REG_CYC_HI: dat_reg <= cyc_hi_snap_reg;
          REG_WDT:    dat_reg <= wdt_reg;
          default:    dat_reg <= '0;
        endcase
      end

      if (!done_reg) cyc_cnt_reg <= cyc_cnt_reg + 64'd1;

      if (wdt_wr)                          wdt_reg <= wb_dat_i;
      else if (wdt_reg != '0 && !done_reg) wdt_reg <= wdt_reg - 32'd1;

      // Software exit outranks a simultaneous expiry; the first exit sticks.
      if (exit_wr) begin
        done_reg      <= 1'b1;
        exit_code_reg <= wb_dat_i[7:0];
      end else if (wdt_expire) begin
        done_reg      <= 1'b1;
        timeout_reg   <= 1'b1;
        exit_code_reg <= EXIT_TIMEOUT;
      end

      if (wr && word == REG_CONSOLE) begin
        char_valid_reg <= 1'b1;
        char_reg       <= wb_dat_i[7:0];
      end
    end
  end

  orpsoc_rst_seq #(
    .NUM_RST          (NUM_RST),
    .RST_STAGE_CYCLES (RST_STAGE_CYCLES)
  ) u_rst_seq (
    .clk   (wb_clk_i),
    .srst  (wb_rst_i),
    .swrst (swrst_req),
    .rst_o (rst_o)
  );

  assign wb_dat_o     = dat_reg;
  assign wb_ack_o     = ack_reg;
  assign wb_err_o     = err_reg;
  assign done_o       = done_reg;
  assign exit_code_o  = exit_code_reg;
  assign timeout_o    = timeout_reg;
  assign char_valid_o = char_valid_reg;
  assign char_o       = char_reg;

endmodule

// File: tb/tb_orpsoc_sim_ctrl.sv
// tb_orpsoc_sim_ctrl
//   Self-checking bench for orpsoc_sim_ctrl (NUM_RST=3, 10-cycle stages,
//   100-cycle watchdog, cycle counter starting just below a 32-bit wrap).
//   Bus responses are checked by a scoreboard queue; register behaviour by
//   a vector table; multi-cycle corners by hand-written sequences.
module tb_orpsoc_sim_ctrl;

  localparam int          NR   = 3;
  localparam int          STG  = 10;
  localparam logic [31:0] TMO  = 32'd100;
  localparam logic [63:0] CINI = 64'h0000_0000_FFFF_FFFC;

  localparam logic [31:0] A_EXIT = 32'h00, A_CON = 32'h04, A_LO = 32'h08;
  localparam logic [31:0] A_HI   = 32'h0C, A_WDT = 32'h10, A_SWR = 32'h14;

  logic          clk = 1'b0;
  logic          wb_rst = 1'b1;
  logic [31:0]   wb_adr = '0, wb_dat = '0;
  logic          wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o, wb_err_o;
  logic [NR-1:0] rst_o;
  logic          done_o, timeout_o, char_valid_o;
  logic [7:0]    exit_code_o, char_o;

  orpsoc_sim_ctrl #(
    .NUM_RST(NR), .RST_STAGE_CYCLES(STG), .TIMEOUT_CYCLES(TMO), .CYC_INIT(CINI)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat),
    .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .rst_o(rst_o), .done_o(done_o), .exit_code_o(exit_code_o),
    .timeout_o(timeout_o), .char_valid_o(char_valid_o), .char_o(char_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic        err;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vec [16];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   char_cnt = 0;
  int   tb_edges = 0;

  // Edges sampled with wb_rst_i low since the last reset.
  always @(posedge clk) begin
    if (wb_rst) tb_edges <= 0;
    else        tb_edges <= tb_edges + 1;
  end

  // Scoreboard: every response pops the oldest expectation.
  always @(negedge clk) begin
    if (char_valid_o) char_cnt++;
    if (wb_ack_o || wb_err_o) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL bus_unexpected: got ack=%0b err=%0b dat=%h, expected no response",
                 wb_ack_o, wb_err_o, wb_dat_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (wb_err_o !== e.err || wb_ack_o !== ~e.err || (e.chk && wb_dat_o !== e.dat)) begin
          n_bad++;
          $display("FAIL bus_resp: got ack=%0b err=%0b dat=%h, expected err=%0b dat=%h (chk=%0b)",
                   wb_ack_o, wb_err_o, wb_dat_o, e.err, e.dat, e.chk);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic bus_start(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic err, input logic chkd, input logic [31:0] exp);
    exp_t e;
    e.err = err; e.chk = chkd; e.dat = exp;
    sb.push_back(e);
    wb_adr = adr; wb_we = we; wb_dat = dat; wb_cyc = 1'b1; wb_stb = 1'b1;
  endtask

  task automatic bus_end();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic sb_drained(input string name);
    chk(name, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // One access: request, response edge, idle edge. Called #1 after an edge.
  task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                      input logic err, input logic chkd, input logic [31:0] exp);
    bus_start(adr, we, dat, err, chkd, exp);
    @(posedge clk); #1;
    bus_end();
    @(posedge clk); #1;
    sb_drained("resp_count");
  endtask

  task automatic do_reset();
    bus_end();
    sb.delete();
    wb_rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_rst_o", 64'(rst_o), 64'h7);
    chk("rst_ack_err", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
    chk("rst_dat_o", 64'(wb_dat_o), 64'd0);
    chk("rst_done_tmo_exit", {54'd0, done_o, timeout_o, exit_code_o}, 64'd0);
    chk("rst_char", {55'd0, char_valid_o, char_o}, 64'd0);
    wb_rst = 1'b0;
  endtask

  task automatic wait_until(input int n);
    for (int i = 0; i < 500 && tb_edges < n; i++) begin
      @(posedge clk); #1;
    end
    chk("wait_edges", 64'(tb_edges), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] e_rst;
    logic [63:0]   e64;
    logic [31:0]   snap;
    int            t_e, cbase;

    vec[0]  = '{A_WDT, 1'b1, 32'd0,         1'b0, 1'b0, 32'd0};
    vec[1]  = '{A_WDT, 1'b0, 32'd0,         1'b0, 1'b1, 32'd0};
    vec[2]  = '{A_WDT, 1'b1, 32'd1000,      1'b0, 1'b0, 32'd0};
    vec[3]  = '{A_WDT, 1'b0, 32'd0,         1'b0, 1'b1, 32'd999};
    vec[4]  = '{A_WDT, 1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 32'd0};
    vec[5]  = '{A_WDT, 1'b0, 32'd0,         1'b0, 1'b1, 32'hDEADBEEE};
    vec[6]  = '{A_WDT, 1'b1, 32'd0,         1'b0, 1'b0, 32'd0};
    vec[7]  = '{A_EXIT, 1'b0, 32'd0,        1'b0, 1'b1, 32'd0};
    vec[8]  = '{A_CON, 1'b0, 32'd0,         1'b0, 1'b1, 32'd0};
    vec[9]  = '{A_SWR, 1'b0, 32'd0,         1'b0, 1'b1, 32'd0};
    vec[10] = '{A_LO,  1'b1, 32'h1234,      1'b0, 1'b0, 32'd0};
    vec[11] = '{32'h18, 1'b0, 32'd0,        1'b1, 1'b0, 32'd0};
    vec[12] = '{32'h1C, 1'b1, 32'h55,       1'b1, 1'b0, 32'd0};
    vec[13] = '{32'h1000_001C, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0};
    vec[14] = '{32'h34, 1'b0, 32'd0,        1'b0, 1'b1, 32'd0};
    vec[15] = '{A_WDT, 1'b0, 32'd0,         1'b0, 1'b1, 32'd0};

    // Staged release: rst_o[k] low from edge (k+1)*10 after release.
    do_reset();
    for (int n = 1; n <= 35; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NR; k++) e_rst[k] = (n < (k + 1) * STG);
      chk($sformatf("seq_e%0d", n), 64'(rst_o), 64'(e_rst));
    end

    // Software restart from RUN.
    bus_start(A_SWR, 1'b1, 32'd1, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    chk("swrst_reassert", 64'(rst_o), 64'b110);
    bus_end();
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk); #1;
      e_rst[0] = 1'b0;
      e_rst[1] = (n < STG);
      e_rst[2] = (n < 2 * STG);
      chk($sformatf("swrst_e%0d", n), 64'(rst_o), 64'(e_rst));
    end
    sb_drained("swrst_resp");

    // Register map vectors.
    do_reset();
    cbase = char_cnt;
    for (int i = 0; i < 16; i++) begin
      $display("vec %0d adr=%h we=%0b dat=%h", i, vec[i].adr, vec[i].we, vec[i].dat);
      xfer(vec[i].adr, vec[i].we, vec[i].dat, vec[i].err, vec[i].chk, vec[i].exp);
    end
    chk("vec_no_char", 64'(char_cnt - cbase), 64'd0);
    chk("vec_not_done", 64'(done_o), 64'd0);

    // Coherent 64-bit counter read across a 32-bit wrap.
    do_reset();
    e64 = CINI + 64'(tb_edges);
    snap = e64[63:32];
    xfer(A_LO, 1'b0, 32'd0, 1'b0, 1'b1, e64[31:0]);
    repeat (5) @(posedge clk);
    #1;
    xfer(A_HI, 1'b0, 32'd0, 1'b0, 1'b1, snap);
    repeat (3) @(posedge clk);
    #1;
    e64 = CINI + 64'(tb_edges);
    chk("cyc_wrapped", 64'(e64[63:32]), 64'd1);
    xfer(A_LO, 1'b0, 32'd0, 1'b0, 1'b1, e64[31:0]);
    xfer(A_HI, 1'b0, 32'd0, 1'b0, 1'b1, 32'd1);

    // Console pulse, then first-exit-wins and counter freeze.
    cbase = char_cnt;
    bus_start(A_CON, 1'b1, 32'h41, 1'b0, 1'b0, 32'd0);
    @(posedge clk); #1;
    chk("char_with_ack", {62'd0, wb_ack_o, char_valid_o}, 64'b11);
    chk("char_o", 64'(char_o), 64'h41);
    bus_end();
    @(posedge clk); #1;
    chk("char_pulse_end", 64'(char_valid_o), 64'd0);
    sb_drained("char_resp");
    t_e = tb_edges;
    xfer(A_EXIT, 1'b1, 32'h00, 1'b0, 1'b0, 32'd0);
    chk("exit_done", {62'd0, done_o, timeout_o}, 64'b10);
    chk("exit_code0", 64'(exit_code_o), 64'h00);
    xfer(A_EXIT, 1'b1, 32'h05, 1'b0, 1'b0, 32'd0);
    chk("exit_first_wins", 64'(exit_code_o), 64'h00);
    e64 = CINI + 64'(t_e) + 64'd1;
    xfer(A_LO, 1'b0, 32'd0, 1'b0, 1'b1, e64[31:0]);
    repeat (4) @(posedge clk);
    #1;
    xfer(A_LO, 1'b0, 32'd0, 1'b0, 1'b1, e64[31:0]);
    chk("char_count", 64'(char_cnt - cbase), 64'd1);

    // Watchdog expiry exactly 100 cycles after release.
    do_reset();
    wait_until(99);
    chk("wdt_e99_done", {62'd0, done_o, timeout_o}, 64'b00);
    @(posedge clk); #1;
    chk("wdt_e100_done", {62'd0, done_o, timeout_o}, 64'b11);
    chk("wdt_e100_code", 64'(exit_code_o), 64'hFF);

    // Reload of 50 at cycle 80 moves expiry to cycle 130.
    do_reset();
    wait_until(79);
    xfer(A_WDT, 1'b1, 32'd50, 1'b0, 1'b0, 32'd0);
    xfer(A_WDT, 1'b0, 32'd0, 1'b0, 1'b1, 32'd49);
    wait_until(129);
    chk("reload_e129", {62'd0, done_o, timeout_o}, 64'b00);
    @(posedge clk); #1;
    chk("reload_e130", {62'd0, done_o, timeout_o}, 64'b11);

    // EXIT on the expiry edge wins.
    do_reset();
    wait_until(99);
    xfer(A_EXIT, 1'b1, 32'h07, 1'b0, 1'b0, 32'd0);
    chk("race_done_tmo", {62'd0, done_o, timeout_o}, 64'b10);
    chk("race_code", 64'(exit_code_o), 64'h07);

    // Held strobe: one response every two cycles.
    do_reset();
    bus_start(A_SWR, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0);
    bus_start(A_SWR, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0);
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      chk($sformatf("held_ack_e%0d", n), 64'(wb_ack_o), 64'(n % 2));
    end
    bus_end();
    @(posedge clk); #1;
    sb_drained("held_resp");

    // Reset during a STAGE wait with an access pending.
    do_reset();
    wait_until(15);
    chk("mid_stage_rst_o", 64'(rst_o), 64'b110);
    wb_adr = A_WDT; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    wb_rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_all_ones", 64'(rst_o), 64'h7);
    chk("mid_rst_no_ack", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
    do_reset();
    @(posedge clk); #1;
    chk("mid_rst_no_late_ack", {62'd0, wb_ack_o, wb_err_o}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
